register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//   Parametrised register file for the MIPS datapath: clocked write port, two
//   combinational read ports, and a per-register busy scoreboard for hazard checks.
//   Sits between decode (read/reserve) and writeback (write/release).
//   Next generation of the unclocked 2R/1W register file; adds clock, reset,
//   a hardwired zero register, an address range check and pending-write tracking.
// PARAMETERS
//   DATA_W    32  register width in bits
//   DEPTH     32  number of registers, 2..64
//   ADDR_W    6   address width; DEPTH <= 2**ADDR_W
//   ZERO_REG  1   1: register 0 reads 0, ignores writes and is never busy
// PORTS
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous, active-high reset
//   R1        in   ADDR_W   read port 1 address
//   R2        in   ADDR_W   read port 2 address
//   RD1       out  DATA_W   read port 1 data (combinational)
//   RD2       out  DATA_W   read port 2 data (combinational)
//   WR        in   ADDR_W   write address
//   WD        in   DATA_W   write data
//   RegWrite  in   1        write enable; also releases the busy bit of WR
//   Reserve   in   1        mark register ResAddr busy (pending producer)
//   ResAddr   in   ADDR_W   register to reserve
//   Busy1     out  1        register R1 has a pending write
//   Busy2     out  1        register R2 has a pending write
//   BusyCnt   out  ADDR_W+1 number of registers currently busy
// BEHAVIOUR
//   - Reset (async, while reset=1): all registers 0, all busy bits 0,
//     BusyCnt 0, so RD1/RD2 read 0 and Busy1/Busy2 read 0. Takes effect
//     mid-cycle; a write or reserve on the same edge as reset release is ignored.
//   - Write: on rising clk with RegWrite=1, regs[WR] <= WD. Visible on RDx
//     from the cycle after the edge (1-cycle write latency).
//   - Read: RDx = regs[Rx] combinationally. Address >= DEPTH: reads 0, Busy 0.
//   - Write to an address >= DEPTH: ignored; busy bits and BusyCnt unchanged.
//   - ZERO_REG=1: writes/reserves to address 0 ignored; RDx=0 and Busyx=0 for Rx=0.
//   - Scoreboard, per clock edge:
//       Reserve=1             -> busy[ResAddr] <= 1
//       RegWrite=1            -> busy[WR] <= 0
//       both, same address    -> busy stays/becomes 1 (new producer wins)
//       Reserve of a busy reg -> stays 1; BusyCnt does not double-count
//       RegWrite to a reg that is not busy -> write occurs; busy stays 0
//   - BusyCnt is registered and always equals the popcount of busy[]; it is
//     updated on the same edge as busy[]; range 0..DEPTH (or DEPTH-1 if ZERO_REG).
//   - Busyx = busy[Rx] from registered state (no same-cycle release).
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-through forwarding. When RegWrite=1,
//     WR==Rx, WR valid (and nonzero if ZERO_REG), RDx=WD in the same cycle,
//     and Busyx=0 that cycle unless Reserve targets the same register.
//   Not defined: RDx shows the old value until after the edge; Busyx follows
//     registered busy[] only. Regs, scoreboard and BusyCnt are the same either way.
// TESTING
//   1 reset=1 mid-run after writes -> RD1=RD2=0, Busy1=Busy2=0, BusyCnt=0 at once.
//   2 WR=1,WD=32'h24,RegWrite=1 one edge; R2=1 -> RD2=32'h24 next cycle;
//     with REGFILE_BYPASS_EN RD2=32'h24 already in the write cycle.
//   3 WR=0,WD=32'h19,RegWrite=1, ZERO_REG=1 -> RD1 (R1=0) stays 0; Reserve at 0
//     -> Busy1=0, BusyCnt=0.
//   4 Reserve ResAddr=5 -> Busy1 (R1=5)=1, BusyCnt=1; repeat Reserve 5 -> BusyCnt=1;
//     RegWrite WR=5 WD=32'hAB -> Busy1=0, BusyCnt=0, RD1=32'hAB.
//   5 Reserve ResAddr=7 and RegWrite WR=7 WD=32'h55 on same edge (7 busy before)
//     -> regs[7]=32'h55, busy[7]=1, BusyCnt unchanged.
//   6 DEPTH=16: RegWrite WR=20 WD=32'hFF -> no register changes; R1=20 -> RD1=0,
//     Busy1=0.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: clocked 2R/1W register file with a per-register busy
// scoreboard. Optional write-through forwarding is compiled in when the
// REGFILE_BYPASS_EN macro is defined; the default build reads registered
// state only.
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] WR,
  input  logic [DATA_W-1:0] WD,
  input  logic              RegWrite,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ResAddr,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   BusyCnt
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nx;
  logic [ADDR_W:0]   cnt_nx;
  logic [DATA_W-1:0] rd1_q, rd2_q;
  logic              b1_q, b2_q;
  logic              wr_ok, res_ok;

  // An address is writable/reservable when in range and not the hardwired zero
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Qualify write and reserve requests against range and the zero register
  always_comb begin
    wr_ok  = RegWrite && addr_ok(WR);
    res_ok = Reserve && addr_ok(ResAddr);
  end

  // Register array write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (WR == ADDR_W'(i)) regs[i] <= WD;
    end
  end

  // Next scoreboard state: release first, then reserve so a new producer wins;
  // the count is the popcount of the next state so it tracks busy[] exactly
  always_comb begin
    busy_nx = busy;
    cnt_nx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ok && (WR == ADDR_W'(i)))       busy_nx[i] = 1'b0;
      if (res_ok && (ResAddr == ADDR_W'(i))) busy_nx[i] = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nx = cnt_nx + {{ADDR_W{1'b0}}, busy_nx[i]};
  end

  // Scoreboard and busy count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      BusyCnt <= '0;
    end else begin
      busy    <= busy_nx;
      BusyCnt <= cnt_nx;
    end
  end

  // Registered-state read mux; out-of-range addresses read 0 and not busy
  always_comb begin
    rd1_q = '0;
    rd2_q = '0;
    b1_q  = 1'b0;
    b2_q  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (R1 == ADDR_W'(i)) begin
        rd1_q = regs[i];
        b1_q  = busy[i];
      end
      if (R2 == ADDR_W'(i)) begin
        rd2_q = regs[i];
        b2_q  = busy[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write; busy only if a new producer reserves it now
  always_comb begin
    RD1   = rd1_q;
    RD2   = rd2_q;
    Busy1 = b1_q;
    Busy2 = b2_q;
    if (wr_ok && (WR == R1)) begin
      RD1   = WD;
      Busy1 = res_ok && (ResAddr == R1);
    end
    if (wr_ok && (WR == R2)) begin
      RD2   = WD;
      Busy2 = res_ok && (ResAddr == R2);
    end
  end
`else
  // Read ports present registered state only
  always_comb begin
    RD1   = rd1_q;
    RD2   = rd2_q;
    Busy1 = b1_q;
    Busy2 = b2_q;
  end
`endif

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed and randomized checks of register_file_sb
// (DEPTH=16 so out-of-range addresses are reachable) against an array model.
module tb_register_file_sb;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] R1, R2, WR, ResAddr;
  logic [DW-1:0] RD1, RD2, WD;
  logic          RegWrite, Reserve, Busy1, Busy2;
  logic [AW:0]   BusyCnt;

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] m_regs [64];
  bit            m_busy [64];

  register_file_sb #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .R1(R1), .R2(R2), .RD1(RD1), .RD2(RD2),
    .WR(WR), .WD(WD), .RegWrite(RegWrite), .Reserve(Reserve),
    .ResAddr(ResAddr), .Busy1(Busy1), .Busy2(Busy2), .BusyCnt(BusyCnt)
  );

  always #5 clk = ~clk;

  function automatic bit writable(input logic [AW-1:0] a);
    return (a < DP) && (a != 0);
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (a >= DP) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WR == a && writable(a)) return WD;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a);
    if (a >= DP) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WR == a && writable(a)) return Reserve && ResAddr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 64; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    if (reset) return;
    if (RegWrite && writable(WR)) begin
      m_regs[WR] = WD;
      m_busy[WR] = 1'b0;
    end
    if (Reserve && writable(ResAddr)) m_busy[ResAddr] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd1"}, 64'(RD1), 64'(m_rd(R1)));
    chk({tag, ".rd2"}, 64'(RD2), 64'(m_rd(R2)));
    chk({tag, ".busy1"}, 64'(Busy1), 64'(m_bsy(R1)));
    chk({tag, ".busy2"}, 64'(Busy2), 64'(m_bsy(R2)));
    chk({tag, ".cnt"}, 64'(BusyCnt), 64'(m_cnt()));
  endtask

  task automatic tick(input string tag);
    m_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_clear();
    reset = 1'b1; R1 = '0; R2 = '0; WR = '0; WD = '0;
    RegWrite = 1'b0; Reserve = 1'b0; ResAddr = '0;
    #2;
    check_all("reset0");
    @(posedge clk); #1;
    reset = 1'b0;

    // write to r1, visible next cycle
    R2 = 6'd1; WR = 6'd1; WD = 32'h24; RegWrite = 1'b1;
    #1 check_all("wr1.pre");
    tick("wr1.edge");
    RegWrite = 1'b0;
    #1 chk("wr1.rd2", 64'(RD2), 64'h24);

    // zero register ignores writes and reserves
    R1 = '0; WR = '0; WD = 32'h19; RegWrite = 1'b1;
    tick("zero.wr");
    RegWrite = 1'b0; Reserve = 1'b1; ResAddr = '0;
    tick("zero.res");
    Reserve = 1'b0;
    #1 chk("zero.rd1", 64'(RD1), 64'h0);
    chk("zero.busy1", 64'(Busy1), 64'h0);
    chk("zero.cnt", 64'(BusyCnt), 64'h0);

    // reserve, re-reserve, release
    R1 = 6'd5; Reserve = 1'b1; ResAddr = 6'd5;
    tick("res5.a");
    chk("res5.busy1", 64'(Busy1), 64'h1);
    chk("res5.cnt", 64'(BusyCnt), 64'h1);
    tick("res5.b");
    chk("res5.cnt2", 64'(BusyCnt), 64'h1);
    Reserve = 1'b0; RegWrite = 1'b1; WR = 6'd5; WD = 32'hAB;
    tick("rel5");
    RegWrite = 1'b0;
    #1 chk("rel5.busy1", 64'(Busy1), 64'h0);
    chk("rel5.cnt", 64'(BusyCnt), 64'h0);
    chk("rel5.rd1", 64'(RD1), 64'hAB);

    // reserve and release on the same edge: new producer wins
    Reserve = 1'b1; ResAddr = 6'd7;
    tick("res7");
    RegWrite = 1'b1; WR = 6'd7; WD = 32'h55;
    tick("both7");
    RegWrite = 1'b0; Reserve = 1'b0; R1 = 6'd7;
    #1 chk("both7.rd1", 64'(RD1), 64'h55);
    chk("both7.busy1", 64'(Busy1), 64'h1);
    chk("both7.cnt", 64'(BusyCnt), 64'h1);

    // out-of-range write and reserve are ignored
    RegWrite = 1'b1; WR = 6'd20; WD = 32'hFF; Reserve = 1'b1; ResAddr = 6'd20; R1 = 6'd20;
    tick("oor");
    RegWrite = 1'b0; Reserve = 1'b0;
    #1 chk("oor.rd1", 64'(RD1), 64'h0);
    chk("oor.busy1", 64'(Busy1), 64'h0);
    chk("oor.cnt", 64'(BusyCnt), 64'h1);

    // randomized traffic, checking both before and after each edge
    for (int n = 0; n < 300; n++) begin
      R1 = AW'($urandom_range(0, 20));
      R2 = AW'($urandom_range(0, 20));
      WR = AW'($urandom_range(0, 20));
      ResAddr = AW'($urandom_range(0, 20));
      WD = $urandom;
      RegWrite = 1'($urandom_range(0, 1));
      Reserve = 1'($urandom_range(0, 1));
      #1 check_all("rnd.pre");
      tick("rnd.post");
    end

    // mid-cycle asynchronous reset, held across an edge with traffic
    RegWrite = 1'b1; Reserve = 1'b1; WR = 6'd3; ResAddr = 6'd4; R1 = 6'd3; R2 = 6'd4;
    #1 reset = 1'b1;
    m_clear();
    #1 check_all("areset");
    tick("areset.edge");
    chk("areset.rd1", 64'(RD1), 64'h0);
    chk("areset.cnt", 64'(BusyCnt), 64'h0);
    RegWrite = 1'b0; Reserve = 1'b0;
    #2 reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      R1 = AW'($urandom_range(0, 17));
      R2 = AW'($urandom_range(0, 17));
      WR = AW'($urandom_range(0, 17));
      ResAddr = AW'($urandom_range(0, 17));
      WD = $urandom;
      RegWrite = 1'($urandom_range(0, 1));
      Reserve = 1'($urandom_range(0, 1));
      tick("rnd2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
